sram_port_arbiter: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 25 ++
 rtl/rr_arbiter2.sv | 59 +++++
 rtl/sram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
//
// sram_arb_pkg
// Shared definitions for the SRAM port-0 arbiter slice: arbiter FSM states,
// requester ids and the default bus widths of the SRAM macro.
//
// Contents:
//   arbState_e          ST_INIT (zero-fill sweep) / ST_RUN (normal arbitration)
//   REQ_M0 / REQ_M1     requester ids as stored in last-grant and read-id registers
//   DEFAULT_*           default widths matching the SRAM macro
//
package sram_arb_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } arbState_e;

   localparam logic REQ_M0 = 1'b0;
   localparam logic REQ_M1 = 1'b1;

   localparam int DEFAULT_ADDR_WIDTH = 17;
   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_NUM_WMASKS = 4;

endpackage

// File: rtl/rr_arbiter2.sv
//
// rr_arbiter2
// Two-way arbiter with a last-grant register. In round-robin mode a conflict
// goes to the requester that was not granted last; in fixed-priority mode
// requester 0 always wins. The grant is purely combinational from req_i.
//
// Ports:
//   clk_i         clock
//   rst_ni        synchronous active-low reset (last grant -> m1)
//   req_i[1:0]    request vector, bit 0 = m0, bit 1 = m1
//   advance_i     allow the last-grant register to update on a grant
//   fixed_prio_i  1 = m0 always wins, 0 = round-robin
//   gnt_o[1:0]    one-hot grant (or zero when nobody requests)
//
module rr_arbiter2
   import sram_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   input  logic       fixed_prio_i,
   output logic [1:0] gnt_o
);

   logic lastGrant_q;
   logic lastGrant_d;

   // Grant selection. Only a true conflict consults the priority scheme; a
   // single requester is simply passed through. gnt_o[1] doubles as the id of
   // the winner since REQ_M1 is 1.
   always_comb begin
      gnt_o       = 2'b00;
      lastGrant_d = lastGrant_q;
      if (req_i == 2'b11) begin
         if (fixed_prio_i || (lastGrant_q == REQ_M1)) begin
            gnt_o = 2'b01;
         end else begin
            gnt_o = 2'b10;
         end
      end else begin
         gnt_o = req_i;
      end
      if (advance_i && (gnt_o != 2'b00)) begin
         lastGrant_d = gnt_o[1];
      end
   end

   // Last-grant register. Resetting to m1 makes m0 the winner of the first
   // conflict after reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lastGrant_q <= REQ_M1;
      end else begin
         lastGrant_q <= lastGrant_d;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
//
// sram_port_arbiter
// Shares SRAM port 0 between an instruction-fetch requester (m0) and a data
// load/store requester (m1). Optionally zero-fills the whole array after
// reset before any request is accepted. Read data is routed back with a
// one-cycle rvalid pulse on the master that issued the read.
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   mX_req_i/we_i/be_i/addr_i/wdata_i   request from master X (held until gnt)
//   mX_gnt_o                      request accepted this cycle (combinational)
//   mX_rvalid_o, mX_rdata_o       read response, one cycle after the grant
//   init_done_o                   high while requests are being accepted
//   sram_csb0_o, sram_web0_o      active-low chip select / write enable
//   sram_wmask0_o, sram_addr0_o, sram_din0_o   port-0 mask, address, data
//   sram_dout0_i                  port-0 read data, valid the cycle after a read
//
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int NUM_WMASKS = DEFAULT_NUM_WMASKS,
   parameter int FIXED_PRIO = 0,
   parameter int ZERO_INIT  = 0
)(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  m0_req_i,
   input  logic                  m0_we_i,
   input  logic [NUM_WMASKS-1:0] m0_be_i,
   input  logic [ADDR_WIDTH-1:0] m0_addr_i,
   input  logic [DATA_WIDTH-1:0] m0_wdata_i,
   input  logic                  m1_req_i,
   input  logic                  m1_we_i,
   input  logic [NUM_WMASKS-1:0] m1_be_i,
   input  logic [ADDR_WIDTH-1:0] m1_addr_i,
   input  logic [DATA_WIDTH-1:0] m1_wdata_i,
   output logic                  m0_gnt_o,
   output logic                  m1_gnt_o,
   output logic                  m0_rvalid_o,
   output logic                  m1_rvalid_o,
   output logic [DATA_WIDTH-1:0] m0_rdata_o,
   output logic [DATA_WIDTH-1:0] m1_rdata_o,
   output logic                  init_done_o,
   output logic                  sram_csb0_o,
   output logic                  sram_web0_o,
   output logic [NUM_WMASKS-1:0] sram_wmask0_o,
   output logic [ADDR_WIDTH-1:0] sram_addr0_o,
   output logic [DATA_WIDTH-1:0] sram_din0_o,
   input  logic [DATA_WIDTH-1:0] sram_dout0_i
);

   arbState_e             state_q;
   arbState_e             state_d;
   logic [ADDR_WIDTH-1:0] sweepCnt_q;
   logic [ADDR_WIDTH-1:0] sweepCnt_d;
   logic                  rdPend_q;
   logic                  rdPend_d;
   logic                  rdId_q;
   logic                  rdId_d;
   logic                  running;
   logic                  sweeping;
   logic [1:0]            reqVec;
   logic [1:0]            gntVec;

   // While rst_ni is held low the port is kept quiet even though the state
   // registers only clear on the next edge, so a reset never lets a grant or
   // a sweep write slip through.
   assign running  = rst_ni && (state_q == ST_RUN);
   assign sweeping = rst_ni && (state_q == ST_INIT);
   assign reqVec   = running ? {m1_req_i, m0_req_i} : 2'b00;

   rr_arbiter2 uArb (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_i        (reqVec),
      .advance_i    (running),
      .fixed_prio_i (FIXED_PRIO != 0),
      .gnt_o        (gntVec)
   );

   // Next-state and SRAM port mux. INIT writes zero to the address held in
   // the sweep counter every cycle and leaves on the all-ones address; RUN
   // forwards the winning master's fields. The read pipeline records whether
   // the winner issued a read and which master it was.
   always_comb begin
      state_d       = state_q;
      sweepCnt_d    = sweepCnt_q;
      rdPend_d      = 1'b0;
      rdId_d        = REQ_M0;
      m0_gnt_o      = gntVec[0];
      m1_gnt_o      = gntVec[1];
      sram_csb0_o   = 1'b1;
      sram_web0_o   = 1'b1;
      sram_wmask0_o = '0;
      sram_addr0_o  = '0;
      sram_din0_o   = '0;
      if (sweeping) begin
         sram_csb0_o   = 1'b0;
         sram_web0_o   = 1'b0;
         sram_wmask0_o = '1;
         sram_addr0_o  = sweepCnt_q;
         sweepCnt_d    = sweepCnt_q + 1'b1;
         if (&sweepCnt_q) begin
            state_d = ST_RUN;
         end
      end else if (gntVec[0]) begin
         sram_csb0_o   = 1'b0;
         sram_web0_o   = ~m0_we_i;
         sram_wmask0_o = m0_be_i;
         sram_addr0_o  = m0_addr_i;
         sram_din0_o   = m0_wdata_i;
         rdPend_d      = ~m0_we_i;
         rdId_d        = REQ_M0;
      end else if (gntVec[1]) begin
         sram_csb0_o   = 1'b0;
         sram_web0_o   = ~m1_we_i;
         sram_wmask0_o = m1_be_i;
         sram_addr0_o  = m1_addr_i;
         sram_din0_o   = m1_wdata_i;
         rdPend_d      = ~m1_we_i;
         rdId_d        = REQ_M1;
      end
   end

   // State, sweep counter and read-response registers. Reset restarts the
   // sweep at address 0 and drops any read still in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= (ZERO_INIT != 0) ? ST_INIT : ST_RUN;
         sweepCnt_q <= '0;
         rdPend_q   <= 1'b0;
         rdId_q     <= REQ_M0;
      end else begin
         state_q    <= state_d;
         sweepCnt_q <= sweepCnt_d;
         rdPend_q   <= rdPend_d;
         rdId_q     <= rdId_d;
      end
   end

   // Read data is shared by both masters; rvalid tells each one whether it
   // is theirs. rvalid is also masked while reset is held.
   assign m0_rvalid_o = rst_ni && rdPend_q && (rdId_q == REQ_M0);
   assign m1_rvalid_o = rst_ni && rdPend_q && (rdId_q == REQ_M1);
   assign m0_rdata_o  = sram_dout0_i;
   assign m1_rdata_o  = sram_dout0_i;
   assign init_done_o = running;

endmodule

// File: tb/tb_sram_port_arbiter.sv
//
// tb_sram_port_arbiter
// Two arbiter instances share one set of request stimulus:
//   dutA: ADDR_WIDTH=4, ZERO_INIT=1, round-robin (SRAM preloaded with all ones)
//   dutB: ADDR_WIDTH=5, ZERO_INIT=0, fixed priority (SRAM preloaded C0DE0000+i)
// Only the instance selected by dutSel is out of reset and checked.
//
module tb_sram_port_arbiter;

   typedef struct {
      logic        r0;
      logic        w0;
      logic [3:0]  b0;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic        r1;
      logic        w1;
      logic [3:0]  b1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic        eg0;
      logic        eg1;
      logic        ev0;
      logic        ev1;
      logic [31:0] erd;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstA;
   logic        rstB;
   logic        dutSel;
   logic        m0Req, m0We, m1Req, m1We;
   logic [3:0]  m0Be, m1Be;
   logic [4:0]  m0Addr, m1Addr;
   logic [31:0] m0Wdata, m1Wdata;

   logic        aGnt0, aGnt1, aRv0, aRv1, aInit, aCsb, aWeb;
   logic [3:0]  aMask, aAddr;
   logic [31:0] aRd0, aRd1, aDin, aDout;
   logic        bGnt0, bGnt1, bRv0, bRv1, bInit, bCsb, bWeb;
   logic [3:0]  bMask;
   logic [4:0]  bAddr;
   logic [31:0] bRd0, bRd1, bDin, bDout;

   logic        gnt0, gnt1, rv0, rv1, initDone, csb, web;
   logic [4:0]  addrMux;
   logic [31:0] rd0, rd1;

   int testsRun  = 0;
   int failCount = 0;

   initial forever #5 clk = ~clk;

   sram_port_arbiter #(
      .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_WMASKS(4), .FIXED_PRIO(0), .ZERO_INIT(1)
   ) dutA (
      .clk_i(clk), .rst_ni(rstA),
      .m0_req_i(m0Req), .m0_we_i(m0We), .m0_be_i(m0Be), .m0_addr_i(m0Addr[3:0]), .m0_wdata_i(m0Wdata),
      .m1_req_i(m1Req), .m1_we_i(m1We), .m1_be_i(m1Be), .m1_addr_i(m1Addr[3:0]), .m1_wdata_i(m1Wdata),
      .m0_gnt_o(aGnt0), .m1_gnt_o(aGnt1), .m0_rvalid_o(aRv0), .m1_rvalid_o(aRv1),
      .m0_rdata_o(aRd0), .m1_rdata_o(aRd1), .init_done_o(aInit),
      .sram_csb0_o(aCsb), .sram_web0_o(aWeb), .sram_wmask0_o(aMask), .sram_addr0_o(aAddr),
      .sram_din0_o(aDin), .sram_dout0_i(aDout)
   );

   sram_port_arbiter #(
      .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_WMASKS(4), .FIXED_PRIO(1), .ZERO_INIT(0)
   ) dutB (
      .clk_i(clk), .rst_ni(rstB),
      .m0_req_i(m0Req), .m0_we_i(m0We), .m0_be_i(m0Be), .m0_addr_i(m0Addr), .m0_wdata_i(m0Wdata),
      .m1_req_i(m1Req), .m1_we_i(m1We), .m1_be_i(m1Be), .m1_addr_i(m1Addr), .m1_wdata_i(m1Wdata),
      .m0_gnt_o(bGnt0), .m1_gnt_o(bGnt1), .m0_rvalid_o(bRv0), .m1_rvalid_o(bRv1),
      .m0_rdata_o(bRd0), .m1_rdata_o(bRd1), .init_done_o(bInit),
      .sram_csb0_o(bCsb), .sram_web0_o(bWeb), .sram_wmask0_o(bMask), .sram_addr0_o(bAddr),
      .sram_din0_o(bDin), .sram_dout0_i(bDout)
   );

   // Behavioural SRAM for dutA: port inputs sampled at posedge, write or read
   // performed at the following negedge. Preloaded with all ones.
   logic [31:0] memA [16];
   logic        memALoaded = 1'b0;
   logic        aCsbQ = 1'b1, aWebQ = 1'b1;
   logic [3:0]  aMaskQ, aAddrQ;
   logic [31:0] aDinQ;
   always @(posedge clk) begin
      aCsbQ  <= aCsb;
      aWebQ  <= aWeb;
      aMaskQ <= aMask;
      aAddrQ <= aAddr;
      aDinQ  <= aDin;
   end
   always @(negedge clk) begin
      if (!memALoaded) begin
         for (int i = 0; i < 16; i++) memA[i] = 32'hFFFF_FFFF;
         memALoaded = 1'b1;
      end
      if (!aCsbQ) begin
         if (!aWebQ) begin
            for (int b = 0; b < 4; b++)
               if (aMaskQ[b]) memA[aAddrQ][8*b +: 8] = aDinQ[8*b +: 8];
         end else begin
            aDout = memA[aAddrQ];
         end
      end
   end

   // Behavioural SRAM for dutB, same timing, preloaded with C0DE0000 + address.
   logic [31:0] memB [32];
   logic        memBLoaded = 1'b0;
   logic        bCsbQ = 1'b1, bWebQ = 1'b1;
   logic [3:0]  bMaskQ;
   logic [4:0]  bAddrQ;
   logic [31:0] bDinQ;
   always @(posedge clk) begin
      bCsbQ  <= bCsb;
      bWebQ  <= bWeb;
      bMaskQ <= bMask;
      bAddrQ <= bAddr;
      bDinQ  <= bDin;
   end
   always @(negedge clk) begin
      if (!memBLoaded) begin
         for (int i = 0; i < 32; i++) memB[i] = 32'hC0DE_0000 + 32'(i);
         memBLoaded = 1'b1;
      end
      if (!bCsbQ) begin
         if (!bWebQ) begin
            for (int b = 0; b < 4; b++)
               if (bMaskQ[b]) memB[bAddrQ][8*b +: 8] = bDinQ[8*b +: 8];
         end else begin
            bDout = memB[bAddrQ];
         end
      end
   end

   // Route the selected instance's outputs onto the common check signals.
   always_comb begin
      gnt0 = aGnt0; gnt1 = aGnt1; rv0 = aRv0; rv1 = aRv1; initDone = aInit;
      csb = aCsb; web = aWeb; addrMux = {1'b0, aAddr}; rd0 = aRd0; rd1 = aRd1;
      if (dutSel) begin
         gnt0 = bGnt0; gnt1 = bGnt1; rv0 = bRv0; rv1 = bRv1; initDone = bInit;
         csb = bCsb; web = bWeb; addrMux = bAddr; rd0 = bRd0; rd1 = bRd1;
      end
   end

   function automatic vec_t mkVec(
      input logic r0, input logic w0, input logic [3:0] b0, input logic [4:0] a0, input logic [31:0] d0,
      input logic r1, input logic w1, input logic [3:0] b1, input logic [4:0] a1, input logic [31:0] d1,
      input logic eg0, input logic eg1, input logic ev0, input logic ev1, input logic [31:0] erd);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.b0 = b0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.b1 = b1; v.a1 = a1; v.d1 = d1;
      v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1; v.erd = erd;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(posedge clk);
      #1;
      m0Req = v.r0; m0We = v.w0; m0Be = v.b0; m0Addr = v.a0; m0Wdata = v.d0;
      m1Req = v.r1; m1We = v.w1; m1Be = v.b1; m1Addr = v.a1; m1Wdata = v.d1;
   endtask

   task automatic checkVector(input vec_t v, input string tag);
      @(negedge clk);
      #1;
      checkOutput({tag, " gnt0"}, 32'(gnt0), 32'(v.eg0));
      checkOutput({tag, " gnt1"}, 32'(gnt1), 32'(v.eg1));
      checkOutput({tag, " csb0"}, 32'(csb), 32'(!(v.eg0 || v.eg1)));
      checkOutput({tag, " rvalid0"}, 32'(rv0), 32'(v.ev0));
      checkOutput({tag, " rvalid1"}, 32'(rv1), 32'(v.ev1));
      if (v.ev0 || v.ev1)
         checkOutput({tag, " rdata"}, v.ev1 ? rd1 : rd0, v.erd);
   endtask

   task automatic runVectors(input vec_t vs[$], input string tag);
      foreach (vs[i]) begin
         applyStimulus(vs[i]);
         checkVector(vs[i], $sformatf("%s[%0d]", tag, i));
      end
   endtask

   task automatic idleInputs();
      m0Req = 1'b0; m0We = 1'b0; m0Be = 4'h0; m0Addr = '0; m0Wdata = '0;
      m1Req = 1'b0; m1We = 1'b0; m1Be = 4'h0; m1Addr = '0; m1Wdata = '0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t vecsA[$];
      vec_t vecsB[$];
      int   initCycles;
      int   grantsInInit;

      // dutA vectors. A read of address 0 is already in flight when the
      // table starts (m0 held its request across the end of the sweep).
      for (int a = 0; a < 16; a++)
         vecsA.push_back(mkVec(1, 0, 4'h0, 5'(a), 0, 0, 0, 4'h0, 0, 0, 1, 0, 1, 0, 32'h0));
      vecsA.push_back(mkVec(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 32'h0));
      vecsA.push_back(mkVec(1, 1, 4'hF, 5, 32'hAAAAAAAA, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0));
      vecsA.push_back(mkVec(1, 1, 4'h5, 5, 32'h11223344, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0));
      vecsA.push_back(mkVec(1, 0, 4'h0, 5, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0));
      vecsA.push_back(mkVec(1, 1, 4'h0, 5, 32'hFFFFFFFF, 0, 0, 4'h0, 0, 0, 1, 0, 1, 0, 32'hAA22AA44));
      vecsA.push_back(mkVec(1, 0, 4'h0, 5, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0, 0, 0));
      vecsA.push_back(mkVec(0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 5, 0, 0, 1, 1, 0, 32'hAA22AA44));
      vecsA.push_back(mkVec(1, 0, 4'h0, 3, 0, 1, 0, 4'h0, 5, 0, 1, 0, 0, 1, 32'hAA22AA44));
      vecsA.push_back(mkVec(1, 0, 4'h0, 3, 0, 1, 0, 4'h0, 5, 0, 0, 1, 1, 0, 32'h0));
      vecsA.push_back(mkVec(1, 0, 4'h0, 3, 0, 1, 0, 4'h0, 5, 0, 1, 0, 0, 1, 32'hAA22AA44));
      vecsA.push_back(mkVec(1, 0, 4'h0, 3, 0, 1, 0, 4'h0, 5, 0, 0, 1, 1, 0, 32'h0));
      vecsA.push_back(mkVec(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 32'hAA22AA44));

      // dutB vectors: single-master write/read, then fixed-priority conflict.
      vecsB.push_back(mkVec(0, 0, 4'h0, 0, 0, 1, 1, 4'hF, 5'h10, 32'hDEADBEEF, 0, 1, 0, 0, 0));
      vecsB.push_back(mkVec(0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 5'h10, 0, 0, 1, 0, 0, 0));
      vecsB.push_back(mkVec(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
      vecsB.push_back(mkVec(1, 0, 4'h0, 1, 0, 1, 0, 4'h0, 5'h10, 0, 1, 0, 0, 0, 0));
      vecsB.push_back(mkVec(1, 0, 4'h0, 1, 0, 1, 0, 4'h0, 5'h10, 0, 1, 0, 1, 0, 32'hC0DE0001));
      vecsB.push_back(mkVec(1, 0, 4'h0, 1, 0, 1, 0, 4'h0, 5'h10, 0, 1, 0, 1, 0, 32'hC0DE0001));
      vecsB.push_back(mkVec(0, 0, 4'h0, 0, 0, 1, 0, 4'h0, 5'h10, 0, 0, 1, 1, 0, 32'hC0DE0001));
      vecsB.push_back(mkVec(0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));

      // ---------------- dutA: reset, zero-fill sweep ----------------
      dutSel = 1'b0;
      rstA   = 1'b0;
      rstB   = 1'b0;
      idleInputs();
      m0Req  = 1'b1;
      m1Req  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("A reset gnt0", 32'(gnt0), 32'd0);
      checkOutput("A reset gnt1", 32'(gnt1), 32'd0);
      checkOutput("A reset csb0", 32'(csb), 32'd1);
      checkOutput("A reset init_done", 32'(initDone), 32'd0);
      checkOutput("A reset rvalid0", 32'(rv0), 32'd0);

      @(posedge clk);
      #1;
      rstA  = 1'b1;
      m1Req = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("A sweep first addr", 32'(addrMux), 32'd0);
      checkOutput("A sweep web0", 32'(web), 32'd0);
      initCycles   = 0;
      grantsInInit = 0;
      while (!initDone && initCycles < 100) begin
         if (gnt0 || gnt1) grantsInInit++;
         initCycles++;
         @(negedge clk);
         #1;
      end
      checkOutput("A init cycles", 32'(initCycles), 32'd16);
      checkOutput("A grants during init", 32'(grantsInInit), 32'd0);

      // ---------------- dutA: table (zero reads, byte mask, round-robin) ----------------
      runVectors(vecsA, "A");

      // ---------------- dutA: reset after a read grant ----------------
      @(posedge clk);
      #1;
      m0Req = 1'b1; m0We = 1'b0; m0Addr = 5'd5;
      @(negedge clk);
      #1;
      checkOutput("A pre-reset gnt0", 32'(gnt0), 32'd1);
      @(posedge clk);
      #1;
      rstA = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("A rst cycle rvalid0", 32'(rv0), 32'd0);
      checkOutput("A rst cycle gnt0", 32'(gnt0), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("A after rst edge rvalid0", 32'(rv0), 32'd0);
      checkOutput("A after rst edge csb0", 32'(csb), 32'd1);
      checkOutput("A after rst edge init_done", 32'(initDone), 32'd0);

      // Release, let the sweep advance, then reset mid-sweep: it must restart at 0.
      @(posedge clk);
      #1;
      rstA = 1'b1;
      idleInputs();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         checkOutput($sformatf("A resweep addr %0d", k), 32'(addrMux), 32'(k));
      end
      @(posedge clk);
      #1;
      rstA = 1'b0;
      @(posedge clk);
      #1;
      rstA = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("A mid-sweep restart addr", 32'(addrMux), 32'd0);
      checkOutput("A mid-sweep restart csb0", 32'(csb), 32'd0);
      @(posedge clk);
      #1;
      rstA = 1'b0;

      // ---------------- dutB: fixed priority, no sweep ----------------
      dutSel = 1'b1;
      m1Req  = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("B reset gnt1", 32'(gnt1), 32'd0);
      checkOutput("B reset csb0", 32'(csb), 32'd1);
      checkOutput("B reset init_done", 32'(initDone), 32'd0);
      @(posedge clk);
      #1;
      rstB = 1'b1;
      idleInputs();
      @(negedge clk);
      #1;
      checkOutput("B init_done after release", 32'(initDone), 32'd1);
      checkOutput("B idle csb0", 32'(csb), 32'd1);

      runVectors(vecsB, "B");

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
